// File: rtl/udp_rx_pkg.sv
// Package: udp_rx_pkg
// Shared constants for the UDP receive demultiplexer: Ethernet/IPv4/UDP header
// byte offsets, protocol codes, FSM state encodings and byte-lane helpers.
package udp_rx_pkg;

    // Header byte offsets, counted from the first destination-MAC byte.
    localparam logic [5:0] OFF_MAC_LAST = 6'd5;
    localparam logic [5:0] OFF_TYPE_HI  = 6'd12;
    localparam logic [5:0] OFF_TYPE_LO  = 6'd13;
    localparam logic [5:0] OFF_VER_IHL  = 6'd14;
    localparam logic [5:0] OFF_PROTO    = 6'd23;
    localparam logic [5:0] OFF_SRC_IP   = 6'd26;
    localparam logic [5:0] OFF_DST_IP   = 6'd30;
    localparam logic [5:0] OFF_SRC_PORT = 6'd34;
    localparam logic [5:0] OFF_DST_PORT = 6'd36;
    localparam logic [5:0] OFF_UDP_LEN  = 6'd38;
    localparam logic [5:0] OFF_HDR_LAST = 6'd41;
    localparam logic [5:0] CNT_SAT      = 6'd42;

    localparam logic [15:0] ETH_TYPE_IP  = 16'h0800;
    localparam logic [15:0] ETH_TYPE_ARP = 16'h0806;
    localparam logic [7:0]  IP_VER_IHL   = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP = 8'h11;
    localparam logic [47:0] BCAST_MAC    = 48'hffff_ffff_ffff;
    localparam logic [15:0] UDP_HDR_LEN  = 16'd8;

    // FSM state encodings
    localparam logic [1:0] ST_HDR  = 2'd0;
    localparam logic [1:0] ST_ARP  = 2'd1;
    localparam logic [1:0] ST_PAY  = 2'd2;
    localparam logic [1:0] ST_DROP = 2'd3;

    // MAC byte expected at header offset idx (0 = most significant byte).
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [5:0] idx);
        case (idx)
            6'd0:    mac_byte = mac[47:40];
            6'd1:    mac_byte = mac[39:32];
            6'd2:    mac_byte = mac[31:24];
            6'd3:    mac_byte = mac[23:16];
            6'd4:    mac_byte = mac[15:8];
            default: mac_byte = mac[7:0];
        endcase
    endfunction

    // Destination-IP byte expected at header offset idx (30..33).
    function automatic logic [7:0] ip_byte(input logic [31:0] ip, input logic [5:0] idx);
        case (idx)
            OFF_DST_IP:         ip_byte = ip[31:24];
            OFF_DST_IP + 6'd1:  ip_byte = ip[23:16];
            OFF_DST_IP + 6'd2:  ip_byte = ip[15:8];
            default:            ip_byte = ip[7:0];
        endcase
    endfunction

endpackage

// File: rtl/udp_rx_demux_if.sv
// Interface: udp_rx_demux_if
// Byte-wide AXI-stream style link (tdata/tvalid/tlast/tready).
//  master: drives tdata, tvalid, tlast; receives tready
//  slave : receives tdata, tvalid, tlast; drives tready
interface udp_rx_demux_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/udp_port_match.sv
// Module: udp_port_match
// Priority compare of a UDP destination port against the NUM_CH configured
// channel ports; the lowest matching channel index wins.
//  port : destination port under test
//  hit  : some channel matches
//  ch   : index of the lowest matching channel (0 when no hit)
module udp_port_match #(
    parameter int                   NUM_CH    = 4,
    parameter logic [NUM_CH*16-1:0] UDP_PORTS = '0
) (
    input  logic [15:0] port,
    output logic        hit,
    output logic [2:0]  ch
);

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        hit = 1'b0;
        ch  = 3'd0;
        // Scan from the top so the lowest matching index is written last.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (UDP_PORTS[16*i +: 16] == port) begin
                hit = 1'b1;
                ch  = 3'(i);
            end
        end
    end

endmodule

// File: rtl/udp_rx_demux.sv
// Module: udp_rx_demux
// Parses a byte-wide Ethernet frame stream, forwards ARP bodies to the arp link
// and UDP payloads to one of NUM_CH channels chosen by destination port.
// Frames failing the MAC/IP/protocol/port filters are discarded and counted.
//  clk, reset         : clock, synchronous active-high reset
//  local_mac_addr/ip  : own addresses used by the filters
//  axis (slave)       : incoming frame bytes
//  arp (master)       : ARP body (frame bytes 14..end), zero latency
//  udp_*              : shared payload data/last/err, one-hot valid, per-channel ready
//  udp_length_out, udp_src_port_out, remote_ip_addr_out : current datagram info
//  drop_cnt_out       : saturating count of dropped frames
module udp_rx_demux
    import udp_rx_pkg::*;
#(
    parameter int                   NUM_CH       = 4,
    parameter logic [NUM_CH*16-1:0] UDP_PORTS    = {16'd5003, 16'd5002, 16'd5001, 16'd5000},
    parameter bit                   ACCEPT_BCAST = 1'b1,
    parameter int                   DROP_CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [47:0]           local_mac_addr,
    input  logic [31:0]           local_ip_addr,
    udp_rx_demux_if.slave         axis,
    udp_rx_demux_if.master        arp,
    output logic [7:0]            udp_tdata_out,
    output logic [NUM_CH-1:0]     udp_tvalid_out,
    output logic                  udp_tlast_out,
    output logic                  udp_terr_out,
    input  logic [NUM_CH-1:0]     udp_tready_in,
    output logic [15:0]           udp_length_out,
    output logic [15:0]           udp_src_port_out,
    output logic [31:0]           remote_ip_addr_out,
    output logic [DROP_CNT_W-1:0] drop_cnt_out
);

    logic [1:0]        state;
    logic [5:0]        cnt;
    logic              mac_loc, mac_bc;
    logic [7:0]        type_hi;
    logic [15:0]       dst_port, udp_len, rem;
    logic [2:0]        ch;
    logic [NUM_CH-1:0] ch_oh;

    logic        beat, loc_nxt, bc_nxt, hdr_fail, len8_end, drop_ev, port_hit;
    logic [2:0]  port_ch;
    logic [15:0] eth_type;

    udp_port_match #(.NUM_CH(NUM_CH), .UDP_PORTS(UDP_PORTS)) u_match (
        .port (dst_port),
        .hit  (port_hit),
        .ch   (port_ch)
    );

    assign beat     = axis.tvalid && axis.tready;
    assign eth_type = {type_hi, axis.tdata};
    assign len8_end = (cnt == OFF_HDR_LAST) && (udp_len == UDP_HDR_LEN);

    always_comb begin
        // Running MAC matches; each restarts on byte 0.
        loc_nxt = (cnt == 6'd0 || mac_loc) && (axis.tdata == mac_byte(local_mac_addr, cnt));
        bc_nxt  = (cnt == 6'd0 || mac_bc)  && (axis.tdata == mac_byte(BCAST_MAC, cnt)) && ACCEPT_BCAST;
        hdr_fail = ((cnt == OFF_MAC_LAST) && !(loc_nxt || bc_nxt))
                || ((cnt == OFF_TYPE_LO)  && eth_type != ETH_TYPE_IP && eth_type != ETH_TYPE_ARP)
                || ((cnt == OFF_VER_IHL)  && axis.tdata != IP_VER_IHL)
                || ((cnt == OFF_PROTO)    && axis.tdata != IP_PROTO_UDP)
                || ((cnt >= OFF_DST_IP) && (cnt <= OFF_DST_IP + 6'd3)
                    && axis.tdata != ip_byte(local_ip_addr, cnt))
                || ((cnt == OFF_HDR_LAST) && (!port_hit || udp_len < UDP_HDR_LEN));
        // A zero-payload datagram is not a drop even when its frame ends at byte 41.
        drop_ev = beat && (state == ST_HDR) && (hdr_fail || (axis.tlast && !len8_end));
    end

    // NOTE: sequential state uses non-blocking assignments; where two apply in one
    // cycle the later one in program order wins (used for the cnt restart below).
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= ST_HDR;
            cnt                <= 6'd0;
            mac_loc            <= 1'b0;
            mac_bc             <= 1'b0;
            type_hi            <= 8'd0;
            dst_port           <= 16'd0;
            udp_len            <= 16'd0;
            rem                <= 16'd0;
            ch                 <= 3'd0;
            udp_length_out     <= 16'd0;
            udp_src_port_out   <= 16'd0;
            remote_ip_addr_out <= 32'd0;
        end else if (beat) begin
            case (state)
                ST_HDR: begin
                    if (cnt < CNT_SAT) cnt <= cnt + 6'd1;
                    if (cnt <= OFF_MAC_LAST) begin
                        mac_loc <= loc_nxt;
                        mac_bc  <= bc_nxt;
                    end
                    if (cnt == OFF_TYPE_HI) type_hi <= axis.tdata;
                    if (cnt >= OFF_SRC_IP && cnt < OFF_SRC_IP + 6'd4)
                        remote_ip_addr_out <= {remote_ip_addr_out[23:0], axis.tdata};
                    if (cnt >= OFF_SRC_PORT && cnt < OFF_SRC_PORT + 6'd2)
                        udp_src_port_out <= {udp_src_port_out[7:0], axis.tdata};
                    if (cnt >= OFF_DST_PORT && cnt < OFF_DST_PORT + 6'd2)
                        dst_port <= {dst_port[7:0], axis.tdata};
                    if (cnt >= OFF_UDP_LEN && cnt < OFF_UDP_LEN + 6'd2)
                        udp_len <= {udp_len[7:0], axis.tdata};

                    if (hdr_fail) begin
                        cnt   <= 6'd0;
                        state <= axis.tlast ? ST_HDR : ST_DROP;
                    end else if (cnt == OFF_HDR_LAST) begin
                        cnt <= 6'd0;
                        if (len8_end || axis.tlast) begin
                            state <= axis.tlast ? ST_HDR : ST_DROP;
                        end else begin
                            state          <= ST_PAY;
                            ch             <= port_ch;
                            rem            <= udp_len - UDP_HDR_LEN;
                            udp_length_out <= udp_len - UDP_HDR_LEN;
                        end
                    end else if (axis.tlast) begin
                        cnt <= 6'd0;
                    end else if (cnt == OFF_TYPE_LO && eth_type == ETH_TYPE_ARP) begin
                        state <= ST_ARP;
                    end
                end
                ST_ARP: begin
                    // Keep counting so the ARP sender IP (frame bytes 28..31) can be captured.
                    if (cnt < CNT_SAT) cnt <= cnt + 6'd1;
                    if (cnt >= OFF_SRC_IP + 6'd2 && cnt < OFF_SRC_IP + 6'd6)
                        remote_ip_addr_out <= {remote_ip_addr_out[23:0], axis.tdata};
                    if (axis.tlast) begin
                        cnt   <= 6'd0;
                        state <= ST_HDR;
                    end
                end
                ST_PAY: begin
                    rem <= rem - 16'd1;
                    if (rem == 16'd1)    state <= axis.tlast ? ST_HDR : ST_DROP;
                    else if (axis.tlast) state <= ST_HDR;
                end
                default: begin
                    if (axis.tlast) state <= ST_HDR;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            drop_cnt_out <= '0;
        else if (drop_ev && !(&drop_cnt_out))
            drop_cnt_out <= drop_cnt_out + DROP_CNT_W'(1);
    end

    // Zero-latency steering; every output is gated so nothing lingers without a valid beat.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) ch_oh[i] = (ch == 3'(i));
        axis.tready    = 1'b1;
        arp.tdata      = 8'd0;
        arp.tvalid     = 1'b0;
        arp.tlast      = 1'b0;
        udp_tdata_out  = 8'd0;
        udp_tvalid_out = '0;
        udp_tlast_out  = 1'b0;
        udp_terr_out   = 1'b0;
        case (state)
            ST_ARP: begin
                axis.tready = arp.tready;
                arp.tvalid  = axis.tvalid;
                arp.tdata   = axis.tvalid ? axis.tdata : 8'd0;
                arp.tlast   = axis.tvalid && axis.tlast;
            end
            ST_PAY: begin
                axis.tready    = |(udp_tready_in & ch_oh);
                udp_tvalid_out = axis.tvalid ? ch_oh : '0;
                udp_tdata_out  = axis.tvalid ? axis.tdata : 8'd0;
                udp_tlast_out  = axis.tvalid && (rem == 16'd1 || axis.tlast);
                udp_terr_out   = axis.tvalid && axis.tlast && (rem != 16'd1);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_udp_rx_demux.sv
// Testbench: tb_udp_rx_demux
// Directed frames for udp_rx_demux; expected output beats are queued when a
// frame is built and popped by a monitor as the DUT emits them.
module tb_udp_rx_demux;

    localparam logic [47:0] LOCAL_MAC = 48'h0200_0000_0001;
    localparam logic [47:0] SRC_MAC   = 48'h0200_0000_0099;
    localparam logic [31:0] LOCAL_IP  = 32'hC0A8_0001;
    localparam logic [31:0] SRC_IP    = 32'h0A00_0002;
    localparam logic [31:0] ARP_SPA   = 32'hC0A8_0063;
    localparam logic [15:0] SRC_PORT  = 16'd1234;
    localparam int          ARP_KIND  = 4;
    localparam int          DROP_MAX  = 3;

    typedef struct {
        int          kind;   // 0..3 udp channel, 4 arp
        logic [7:0]  data;
        logic        last;
        logic        err;
        logic [15:0] len;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  udp_tready_in;
    logic [7:0]  udp_tdata_out;
    logic [3:0]  udp_tvalid_out;
    logic        udp_tlast_out, udp_terr_out;
    logic [15:0] udp_length_out, udp_src_port_out;
    logic [31:0] remote_ip_addr_out;
    logic [1:0]  drop_cnt_out;

    udp_rx_demux_if axis();
    udp_rx_demux_if arp();

    udp_rx_demux #(.DROP_CNT_W(2)) dut (
        .clk                (clk),
        .reset              (reset),
        .local_mac_addr     (LOCAL_MAC),
        .local_ip_addr      (LOCAL_IP),
        .axis               (axis),
        .arp                (arp),
        .udp_tdata_out      (udp_tdata_out),
        .udp_tvalid_out     (udp_tvalid_out),
        .udp_tlast_out      (udp_tlast_out),
        .udp_terr_out       (udp_terr_out),
        .udp_tready_in      (udp_tready_in),
        .udp_length_out     (udp_length_out),
        .udp_src_port_out   (udp_src_port_out),
        .remote_ip_addr_out (remote_ip_addr_out),
        .drop_cnt_out       (drop_cnt_out)
    );

    always #5 clk = ~clk;

    int         tests  = 0;
    int         failed = 0;
    int         exp_drop = 0;
    exp_t       sb[$];
    logic [7:0] frame[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_beat(input int kind, input logic [7:0] d, input logic l, input logic e);
        exp_t x;
        if (sb.size() == 0) begin
            check("unexpected_beat_kind", 32'(kind), 32'hffff);
        end else begin
            x = sb.pop_front();
            check("beat_kind", 32'(kind), 32'(x.kind));
            check("beat_data", 32'(d), 32'(x.data));
            check("beat_last", 32'(l), 32'(x.last));
            check("beat_err",  32'(e), 32'(x.err));
            if (kind != ARP_KIND) check("udp_len_stable", 32'(udp_length_out), 32'(x.len));
        end
    endtask

    // Output monitor, sampling mid-cycle while the beat is about to be accepted.
    always @(negedge clk) begin
        if (!reset) begin
            if (|udp_tvalid_out) check("udp_onehot", 32'($countones(udp_tvalid_out)), 32'd1);
            if (arp.tvalid && arp.tready) compare_beat(ARP_KIND, arp.tdata, arp.tlast, 1'b0);
            for (int c = 0; c < 4; c++)
                if (udp_tvalid_out[c] && udp_tready_in[c])
                    compare_beat(c, udp_tdata_out, udp_tlast_out, udp_terr_out);
        end
    end

    task automatic put(input logic [7:0] b);
        frame.push_back(b);
    endtask

    task automatic put16(input logic [15:0] v);
        put(v[15:8]);
        put(v[7:0]);
    endtask

    task automatic put32(input logic [31:0] v);
        put16(v[31:16]);
        put16(v[15:0]);
    endtask

    // IPv4/UDP frame; exp_ch < 0 means no payload is expected on any channel.
    task automatic build_udp(input logic [47:0] mac, input logic [31:0] ip, input logic [7:0] proto,
                             input logic [15:0] dport, input logic [15:0] ulen,
                             input int npay, input int npad, input int exp_ch);
        logic [7:0] b;
        frame.delete();
        for (int i = 5; i >= 0; i--) put(mac[8*i +: 8]);
        for (int i = 5; i >= 0; i--) put(SRC_MAC[8*i +: 8]);
        put16(16'h0800);
        put(8'h45); put(8'h00); put16(16'd20 + ulen);
        put32(32'h0000_4000); put(8'h40); put(proto); put16(16'h0000);
        put32(SRC_IP); put32(ip);
        put16(SRC_PORT); put16(dport); put16(ulen); put16(16'h0000);
        for (int i = 0; i < npay; i++) begin
            b = 8'($urandom_range(0, 255));
            put(b);
            if (exp_ch >= 0)
                sb.push_back('{exp_ch, b, i == npay - 1,
                               (i == npay - 1) && (npay < int'(ulen) - 8), ulen - 16'd8});
        end
        for (int i = 0; i < npad; i++) put(8'h00);
    endtask

    // Broadcast ARP request: 28-byte body plus 18 pad bytes, all forwarded.
    task automatic build_arp();
        logic [7:0] b;
        frame.delete();
        for (int i = 0; i < 6; i++) put(8'hff);
        for (int i = 5; i >= 0; i--) put(SRC_MAC[8*i +: 8]);
        put16(16'h0806);
        for (int i = 0; i < 46; i++) begin
            if (i >= 14 && i < 18)  b = ARP_SPA[8*(17-i) +: 8];
            else if (i < 28)        b = 8'($urandom_range(0, 255));
            else                    b = 8'h00;
            put(b);
            sb.push_back('{ARP_KIND, b, i == 45, 1'b0, 16'd0});
        end
    endtask

    // Drives one beat and waits (bounded) for it to be accepted; optionally stalls channel 0.
    task automatic send_byte(input logic [7:0] d, input logic last, input logic stall);
        logic acc;
        int   n;
        axis.tdata  = d;
        axis.tvalid = 1'b1;
        axis.tlast  = last;
        if (stall) begin
            udp_tready_in[0] = 1'b0;
            repeat (5) begin
                @(negedge clk);
                check("stall_tready", 32'(axis.tready), 32'd0);
                @(posedge clk); #1;
            end
            udp_tready_in = 4'hf;
        end
        n = 0;
        do begin
            @(negedge clk);
            acc = axis.tready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 100);
        if (!acc) check("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic send_frame(input int stall_at);
        for (int i = 0; i < frame.size(); i++)
            send_byte(frame[i], i == frame.size() - 1, i == stall_at);
        axis.tvalid = 1'b0;
        axis.tlast  = 1'b0;
        axis.tdata  = 8'd0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_drop(input string tag);
        check(tag, 32'(drop_cnt_out), 32'(exp_drop > DROP_MAX ? DROP_MAX : exp_drop));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        axis.tdata    = 8'd0;
        axis.tvalid   = 1'b0;
        axis.tlast    = 1'b0;
        arp.tready    = 1'b1;
        udp_tready_in = 4'hf;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tready",    32'(axis.tready), 32'd1);
        check("rst_arp_valid", 32'(arp.tvalid), 32'd0);
        check("rst_udp_valid", 32'(udp_tvalid_out), 32'd0);
        check("rst_drop",      32'(drop_cnt_out), 32'd0);
        check("rst_length",    32'(udp_length_out), 32'd0);
        check("rst_remote_ip", remote_ip_addr_out, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Port 5001, 10-byte payload then pad: channel 1 only, pad stripped.
        build_udp(LOCAL_MAC, LOCAL_IP, 8'h11, 16'd5001, 16'd18, 10, 8, 1);
        send_frame(-1);
        check("good_length",    32'(udp_length_out), 32'd10);
        check("good_src_port",  32'(udp_src_port_out), 32'(SRC_PORT));
        check("good_remote_ip", remote_ip_addr_out, SRC_IP);
        check("good_sb_empty",  32'(sb.size()), 32'd0);
        check_drop("good_drop");

        // Broadcast ARP: 46 bytes on the arp link.
        build_arp();
        send_frame(-1);
        check("arp_sb_empty",  32'(sb.size()), 32'd0);
        check("arp_remote_ip", remote_ip_addr_out, ARP_SPA);
        check_drop("arp_drop");

        // UDP length 8: nothing emitted, not a drop.
        build_udp(LOCAL_MAC, LOCAL_IP, 8'h11, 16'd5001, 16'd8, 0, 18, -1);
        send_frame(-1);
        check_drop("len8_drop");

        // Filtered frames: counter steps once per frame, then saturates at 3.
        build_udp(LOCAL_MAC, LOCAL_IP, 8'h11, 16'd6000, 16'd18, 10, 8, -1);
        send_frame(-1); exp_drop++;
        check_drop("port6000_drop");
        build_udp(LOCAL_MAC, 32'hC0A8_0002, 8'h11, 16'd5001, 16'd18, 10, 8, -1);
        send_frame(-1); exp_drop++;
        check_drop("dst_ip_drop");
        build_udp(LOCAL_MAC, LOCAL_IP, 8'h06, 16'd5001, 16'd18, 10, 8, -1);
        send_frame(-1); exp_drop++;
        check_drop("proto_drop");
        build_udp(48'h0200_0000_0077, LOCAL_IP, 8'h11, 16'd5001, 16'd18, 10, 8, -1);
        send_frame(-1); exp_drop++;
        check_drop("mac_drop_sat");
        build_udp(LOCAL_MAC, LOCAL_IP, 8'h11, 16'd5001, 16'd18, 10, 8, -1);
        while (frame.size() > 20) void'(frame.pop_back());
        send_frame(-1); exp_drop++;
        check_drop("short_drop_sat");
        check("drops_sb_empty", 32'(sb.size()), 32'd0);

        // Frame cut 4 bytes into a 20-byte payload: last+err on the 4th, next frame normal.
        build_udp(LOCAL_MAC, LOCAL_IP, 8'h11, 16'd5002, 16'd28, 4, 0, 2);
        send_frame(-1);
        build_udp(LOCAL_MAC, LOCAL_IP, 8'h11, 16'd5003, 16'd14, 6, 12, 3);
        send_frame(-1);
        check("trunc_sb_empty", 32'(sb.size()), 32'd0);
        check("after_trunc_length", 32'(udp_length_out), 32'd6);

        // Channel 0 stalled for 5 cycles at payload byte 5.
        build_udp(LOCAL_MAC, LOCAL_IP, 8'h11, 16'd5000, 16'd20, 12, 6, 0);
        send_frame(42 + 5);
        check("stall_sb_empty", 32'(sb.size()), 32'd0);

        // Broadcast destination MAC is accepted for UDP too.
        build_udp(48'hffff_ffff_ffff, LOCAL_IP, 8'h11, 16'd5003, 16'd11, 3, 15, 3);
        send_frame(-1);
        check("bcast_sb_empty", 32'(sb.size()), 32'd0);
        check_drop("final_drop");

        repeat (5) @(posedge clk);
        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
